// File: rtl/bp_be_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_be_pkg
//  Description : Shared types and constants for the back-end register
//                scoreboard: default geometry, pending-count type, flattened
//                source/destination packing types and sizing helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package bp_be_pkg;

    localparam int c_issue_width    = 2;
    localparam int c_num_rs         = 2;
    localparam int c_clear_ports    = 2;
    localparam int c_reg_addr_width = 5;
    localparam int c_cnt_width      = 2;

    // Architectural register file size for the default address width.
    localparam int c_rf_els = 2 ** c_reg_addr_width;

    // Pending-write count held for each architectural register.
    typedef logic [c_cnt_width-1:0] sb_cnt_t;

    typedef logic [c_reg_addr_width-1:0] reg_addr_t;

    // Flattened operand buses: entry (slot*num_rs + src) sits at the LSB end.
    typedef logic [c_issue_width*c_num_rs*c_reg_addr_width-1:0] rs_flat_t;
    typedef logic [c_issue_width*c_reg_addr_width-1:0]          rd_flat_t;

    function automatic int rf_els_f(input int addr_width);
        return 2 ** addr_width;
    endfunction

    // Bits needed to hold a population count of n request lines (0..n).
    function automatic int tally_width_f(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_be_scoreboard_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bp_be_scoreboard_counter
//  Description : Pending-write counter for one architectural register.
//                Adds inc_i and subtracts dec_i each cycle, saturating at
//                the counter maximum and flooring at zero; flush_i forces 0.
//  Revision    : 1.0  initial release
//  Ports       : clk_i, reset_n_i (async active-low), flush_i
//                inc_i       - number of scores targeting this register
//                dec_i       - number of clears targeting this register
//                nonzero_o   - registered count is nonzero
//                overflow_o  - this cycle's update would exceed the maximum
//                underflow_o - this cycle's update would go below zero
// ============================================================================
module bp_be_scoreboard_counter #(
    parameter int CNT_WIDTH = 2,
    parameter int INC_WIDTH = 2,
    parameter int DEC_WIDTH = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 flush_i,
    input  logic [INC_WIDTH-1:0] inc_i,
    input  logic [DEC_WIDTH-1:0] dec_i,
    output logic                 nonzero_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    // Wide enough to hold max count + max inc and to go negative by max dec.
    localparam int c_sum_width = CNT_WIDTH + INC_WIDTH + DEC_WIDTH + 1;
    localparam logic signed [c_sum_width-1:0] c_max = c_sum_width'((2 ** CNT_WIDTH) - 1);

    logic [CNT_WIDTH-1:0]          r_cnt;
    logic signed [c_sum_width-1:0] w_sum;

    assign w_sum = $signed(c_sum_width'(r_cnt)) + $signed(c_sum_width'(inc_i))
                 - $signed(c_sum_width'(dec_i));

    // A flush discards the update, so it cannot overflow or underflow.
    assign overflow_o  = !flush_i && (w_sum > c_max);
    assign underflow_o = !flush_i && w_sum[c_sum_width-1];
    assign nonzero_o   = |r_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt <= '0;
        end else if (flush_i) begin
            r_cnt <= '0;
        end else if (overflow_o) begin
            r_cnt <= '1;
        end else if (underflow_o) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_sum[CNT_WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/bp_be_scoreboard_multi.sv
`default_nettype none
// ============================================================================
//  Module      : bp_be_scoreboard_multi
//  Description : N-issue register scoreboard with a pending-write counter per
//                architectural register. Flags RAW hazards per source and WAW
//                hazards per destination, including hazards against older
//                slots of the same issue bundle.
//  Revision    : 1.0  initial release
//  Ports       : clk_i, reset_n_i (async active-low), flush_i
//                score_v_i/score_rd_i - per-slot score requests
//                clear_v_i/clear_rd_i - per-port writeback clears
//                rs_i, rd_i, rd_v_i   - operands checked per slot
//                rs_match_o, rd_match_o - RAW / WAW hazard flags
//                busy_o - any register pending; err_o - sticky over/underflow
// ============================================================================
module bp_be_scoreboard_multi
    import bp_be_pkg::*;
#(
    parameter int ISSUE_WIDTH    = c_issue_width,
    parameter int NUM_RS         = c_num_rs,
    parameter int CLEAR_PORTS    = c_clear_ports,
    parameter int REG_ADDR_WIDTH = c_reg_addr_width,
    parameter int CNT_WIDTH      = c_cnt_width
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic                                      flush_i,
    input  logic [ISSUE_WIDTH-1:0]                    score_v_i,
    input  logic [ISSUE_WIDTH*REG_ADDR_WIDTH-1:0]     score_rd_i,
    input  logic [CLEAR_PORTS-1:0]                    clear_v_i,
    input  logic [CLEAR_PORTS*REG_ADDR_WIDTH-1:0]     clear_rd_i,
    input  logic [ISSUE_WIDTH*NUM_RS*REG_ADDR_WIDTH-1:0] rs_i,
    input  logic [ISSUE_WIDTH*REG_ADDR_WIDTH-1:0]     rd_i,
    input  logic [ISSUE_WIDTH-1:0]                    rd_v_i,
    output logic [ISSUE_WIDTH*NUM_RS-1:0]             rs_match_o,
    output logic [ISSUE_WIDTH-1:0]                    rd_match_o,
    output logic                                      busy_o,
    output logic                                      err_o
);

    localparam int c_num_regs  = rf_els_f(REG_ADDR_WIDTH);
    localparam int c_inc_width = tally_width_f(ISSUE_WIDTH);
    localparam int c_dec_width = tally_width_f(CLEAR_PORTS);

    logic [c_num_regs-1:0] w_nonzero;
    logic [c_num_regs-1:0] w_ovf;
    logic [c_num_regs-1:0] w_unf;
    logic                  r_err;

    // Register 0 is hardwired: never pending, never in error.
    assign w_nonzero[0] = 1'b0;
    assign w_ovf[0]     = 1'b0;
    assign w_unf[0]     = 1'b0;

    for (genvar r = 1; r < c_num_regs; r++) begin : g_reg
        logic [c_inc_width-1:0] w_inc;
        logic [c_dec_width-1:0] w_dec;

        // Population count of score/clear ports addressing this register.
        always_comb begin
            w_inc = '0;
            for (int s = 0; s < ISSUE_WIDTH; s++) begin
                if (score_v_i[s] &&
                    (score_rd_i[s*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == REG_ADDR_WIDTH'(r))) begin
                    w_inc = w_inc + c_inc_width'(1);
                end
            end
        end

        always_comb begin
            w_dec = '0;
            for (int p = 0; p < CLEAR_PORTS; p++) begin
                if (clear_v_i[p] &&
                    (clear_rd_i[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == REG_ADDR_WIDTH'(r))) begin
                    w_dec = w_dec + c_dec_width'(1);
                end
            end
        end

        bp_be_scoreboard_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .INC_WIDTH (c_inc_width),
            .DEC_WIDTH (c_dec_width)
        ) u_cnt (
            .clk_i       (clk_i),
            .reset_n_i   (reset_n_i),
            .flush_i     (flush_i),
            .inc_i       (w_inc),
            .dec_i       (w_dec),
            .nonzero_o   (w_nonzero[r]),
            .overflow_o  (w_ovf[r]),
            .underflow_o (w_unf[r])
        );
    end

    // Hazard on addr for a given slot: pending in registered state, or
    // scored this cycle by an older valid slot. No same-cycle clear bypass.
    function automatic logic hazard_f(
        input logic [REG_ADDR_WIDTH-1:0]             addr,
        input int                                    slot,
        input logic [c_num_regs-1:0]                 pend,
        input logic [ISSUE_WIDTH-1:0]                sv,
        input logic [ISSUE_WIDTH*REG_ADDR_WIDTH-1:0] srd,
        input logic [ISSUE_WIDTH-1:0]                rv
    );
        logic hit;
        hit = pend[addr];
        for (int m = 0; m < ISSUE_WIDTH; m++) begin
            if ((m < slot) && rv[m] && sv[m] &&
                (srd[m*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == addr)) begin
                hit = 1'b1;
            end
        end
        return (addr != '0) && hit;
    endfunction

    always_comb begin
        rs_match_o = '0;
        rd_match_o = '0;
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
            for (int k = 0; k < NUM_RS; k++) begin
                rs_match_o[j*NUM_RS+k] = hazard_f(
                    rs_i[(j*NUM_RS+k)*REG_ADDR_WIDTH +: REG_ADDR_WIDTH],
                    j, w_nonzero, score_v_i, score_rd_i, rd_v_i);
            end
            rd_match_o[j] = hazard_f(rd_i[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH],
                                     j, w_nonzero, score_v_i, score_rd_i, rd_v_i);
        end
    end

    // Sticky error: only reset clears it; flush leaves it alone.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | (|w_ovf) | (|w_unf);
        end
    end

    assign busy_o = |w_nonzero;
    assign err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bp_be_scoreboard_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_be_scoreboard_multi
//  Description : Self-checking bench for bp_be_scoreboard_multi (default
//                geometry: 2 slots, 2 sources, 2 clear ports, 5-bit
//                addresses, 2-bit counters). Table of per-cycle vectors with
//                hand-computed outputs, then reset/underflow sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bp_be_scoreboard_multi;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b1;
    logic        flush_i;
    logic [1:0]  score_v_i;
    logic [9:0]  score_rd_i;
    logic [1:0]  clear_v_i;
    logic [9:0]  clear_rd_i;
    logic [19:0] rs_i;
    logic [9:0]  rd_i;
    logic [1:0]  rd_v_i;
    logic [3:0]  rs_match_o;
    logic [1:0]  rd_match_o;
    logic        busy_o;
    logic        err_o;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    bp_be_scoreboard_multi dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n_i),
        .flush_i    (flush_i),
        .score_v_i  (score_v_i),
        .score_rd_i (score_rd_i),
        .clear_v_i  (clear_v_i),
        .clear_rd_i (clear_rd_i),
        .rs_i       (rs_i),
        .rd_i       (rd_i),
        .rd_v_i     (rd_v_i),
        .rs_match_o (rs_match_o),
        .rd_match_o (rd_match_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    typedef struct {
        logic [1:0] sv;  logic [4:0] s0;  logic [4:0] s1;
        logic [1:0] cv;  logic [4:0] c0;  logic [4:0] c1;
        logic [4:0] a00; logic [4:0] a01; logic [4:0] a10; logic [4:0] a11;
        logic [4:0] d0;  logic [4:0] d1;
        logic [1:0] rv;  logic fl;
        logic [3:0] ers; logic [1:0] erd; logic eb; logic ee;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] sv, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] cv, input logic [4:0] c0, input logic [4:0] c1,
                       input logic [4:0] a00, input logic [4:0] a01, input logic [4:0] a10, input logic [4:0] a11,
                       input logic [4:0] d0, input logic [4:0] d1, input logic [1:0] rv, input logic fl,
                       input logic [3:0] ers, input logic [1:0] erd, input logic eb, input logic ee);
        vec_t v;
        v.sv = sv;  v.s0 = s0;  v.s1 = s1;  v.cv = cv;  v.c0 = c0;  v.c1 = c1;
        v.a00 = a00; v.a01 = a01; v.a10 = a10; v.a11 = a11;
        v.d0 = d0;  v.d1 = d1;  v.rv = rv;  v.fl = fl;
        v.ers = ers; v.erd = erd; v.eb = eb; v.ee = ee;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        score_v_i  = v.sv;  score_rd_i = {v.s1, v.s0};
        clear_v_i  = v.cv;  clear_rd_i = {v.c1, v.c0};
        rs_i       = {v.a11, v.a10, v.a01, v.a00};
        rd_i       = {v.d1, v.d0};
        rd_v_i     = v.rv;  flush_i    = v.fl;
    endtask

    task automatic idle();
        score_v_i = '0; score_rd_i = '0; clear_v_i = '0; clear_rd_i = '0;
        rs_i = '0; rd_i = '0; rd_v_i = '0; flush_i = 1'b0;
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    initial begin
        idle();
        // Reset state: async assertion, outputs must be quiet.
        #1 reset_n_i = 1'b0;
        #1;
        chk("reset_busy", -1, {3'b0, busy_o}, 4'b0);
        chk("reset_err", -1, {3'b0, err_o}, 4'b0);
        // Scores during reset must not be counted.
        score_v_i = 2'b11; score_rd_i = {5'd2, 5'd1};
        @(posedge clk); @(posedge clk); #1;
        idle();
        reset_n_i = 1'b1;
        #3;
        rs_i = {5'd0, 5'd0, 5'd2, 5'd1};
        #0;
        chk("post_reset_rs", -1, rs_match_o, 4'b0000);
        chk("post_reset_busy", -1, {3'b0, busy_o}, 4'b0);
        @(posedge clk); #1;

        //   sv    s0 s1  cv    c0 c1  a00 a01 a10 a11 d0 d1 rv   fl ers     erd   eb ee
        add(2'b01, 0, 0,  2'b00, 0, 0,  0, 0, 0, 0,   0, 0, 2'b11, 0, 4'b0000, 2'b00, 0, 0); // 0  x0 score
        add(2'b01, 5, 0,  2'b00, 0, 0,  0, 0, 0, 0,   5, 0, 2'b01, 0, 4'b0000, 2'b00, 0, 0); // 1  score 5
        add(2'b00, 0, 0,  2'b01, 5, 0,  5, 0, 0, 0,   0, 5, 2'b00, 0, 4'b0001, 2'b10, 1, 0); // 2  RAW, clear no bypass
        add(2'b00, 0, 0,  2'b00, 0, 0,  5, 0, 0, 0,   0, 0, 2'b00, 0, 4'b0000, 2'b00, 0, 0); // 3  cleared
        add(2'b01, 7, 0,  2'b00, 0, 0,  0, 0, 0, 0,   0, 0, 2'b01, 0, 4'b0000, 2'b00, 0, 0); // 4  WAW #1
        add(2'b01, 7, 0,  2'b00, 0, 0,  0, 0, 0, 7,   0, 0, 2'b00, 0, 4'b1000, 2'b00, 1, 0); // 5  WAW #2
        add(2'b00, 0, 0,  2'b00, 0, 0,  0, 7, 0, 0,   0, 0, 2'b00, 0, 4'b0010, 2'b00, 1, 0); // 6
        add(2'b00, 0, 0,  2'b10, 0, 7,  0, 0, 7, 0,   0, 0, 2'b00, 0, 4'b0100, 2'b00, 1, 0); // 7  clear 1 of 2
        add(2'b00, 0, 0,  2'b01, 7, 0,  7, 0, 0, 0,   0, 0, 2'b00, 0, 4'b0001, 2'b00, 1, 0); // 8  still pending
        add(2'b00, 0, 0,  2'b00, 0, 0,  7, 0, 0, 0,   0, 0, 2'b00, 0, 4'b0000, 2'b00, 0, 0); // 9
        add(2'b01, 9, 0,  2'b00, 0, 0,  9, 0, 9, 0,   0, 9, 2'b10, 0, 4'b0000, 2'b00, 0, 0); // 10 intra, rd_v0=0
        add(2'b01,10, 0,  2'b01, 9, 0, 10, 0,10, 9,  10,10, 2'b01, 0, 4'b1100, 2'b10, 1, 0); // 11 intra fwd
        add(2'b00, 0, 0,  2'b01,10, 0,  9,10, 0, 0,   0, 0, 2'b00, 0, 4'b0010, 2'b00, 1, 0); // 12
        add(2'b10, 0,11,  2'b00, 0, 0, 11, 0,11, 0,   0,11, 2'b11, 0, 4'b0000, 2'b00, 0, 0); // 13 younger no fwd
        add(2'b00, 0, 0,  2'b10, 0,11,  0, 0, 0,11,  11, 0, 2'b00, 0, 4'b1000, 2'b01, 1, 0); // 14
        add(2'b11,12,12,  2'b00, 0, 0,  0, 0,12, 0,   0, 0, 2'b11, 0, 4'b0100, 2'b00, 0, 0); // 15 two scores same rd
        add(2'b00, 0, 0,  2'b11,12,12, 12, 0, 0, 0,   0, 0, 2'b00, 0, 4'b0001, 2'b00, 1, 0); // 16 two clears
        add(2'b00, 0, 0,  2'b00, 0, 0, 12, 0, 0,12,   0, 0, 2'b00, 0, 4'b0000, 2'b00, 0, 0); // 17
        add(2'b01, 8, 0,  2'b00, 0, 0,  0, 0, 0, 0,   0, 0, 2'b00, 0, 4'b0000, 2'b00, 0, 0); // 18 cnt8=1
        add(2'b01, 8, 0,  2'b01, 8, 0,  0, 0, 0, 0,   0, 0, 2'b00, 0, 4'b0000, 2'b00, 1, 0); // 19 score+clear nets 0
        add(2'b00, 0, 0,  2'b00, 0, 0,  8, 0, 0, 0,   0, 0, 2'b00, 0, 4'b0001, 2'b00, 1, 0); // 20
        add(2'b00, 0, 0,  2'b01, 8, 0,  0, 0, 0, 0,   0, 0, 2'b00, 0, 4'b0000, 2'b00, 1, 0); // 21
        add(2'b00, 0, 0,  2'b00, 0, 0,  8, 0, 0, 0,   0, 0, 2'b00, 0, 4'b0000, 2'b00, 0, 0); // 22
        add(2'b11, 4, 6,  2'b00, 0, 0,  0, 0, 0, 0,   0, 0, 2'b00, 0, 4'b0000, 2'b00, 0, 0); // 23 cnt4=cnt6=1
        add(2'b01, 4, 0,  2'b01, 6, 0,  0, 0, 4, 6,   0, 0, 2'b00, 1, 4'b1100, 2'b00, 1, 0); // 24 flush wins
        add(2'b00, 0, 0,  2'b00, 0, 0,  4, 6, 0, 0,   4, 6, 2'b00, 0, 4'b0000, 2'b00, 0, 0); // 25
        add(2'b01, 3, 0,  2'b00, 0, 0,  0, 0, 0, 0,   0, 0, 2'b00, 0, 4'b0000, 2'b00, 0, 0); // 26 cnt3 -> 1
        add(2'b01, 3, 0,  2'b00, 0, 0,  0, 0, 0, 0,   0, 0, 2'b00, 0, 4'b0000, 2'b00, 1, 0); // 27 -> 2
        add(2'b01, 3, 0,  2'b00, 0, 0,  0, 0, 0, 0,   0, 0, 2'b00, 0, 4'b0000, 2'b00, 1, 0); // 28 -> 3
        add(2'b01, 3, 0,  2'b00, 0, 0,  3, 0, 0, 0,   0, 0, 2'b00, 0, 4'b0001, 2'b00, 1, 0); // 29 overflow, holds 3
        add(2'b00, 0, 0,  2'b01, 3, 0,  3, 0, 0, 0,   0, 0, 2'b00, 0, 4'b0001, 2'b00, 1, 1); // 30 err set, 3 -> 2
        add(2'b00, 0, 0,  2'b10, 0, 3,  0, 0, 3, 0,   0, 0, 2'b00, 0, 4'b0100, 2'b00, 1, 1); // 31 -> 1
        add(2'b00, 0, 0,  2'b01, 3, 0,  0, 0, 0, 3,   0, 0, 2'b00, 0, 4'b1000, 2'b00, 1, 1); // 32 -> 0
        add(2'b00, 0, 0,  2'b00, 0, 0,  3, 3, 3, 3,   3, 3, 2'b00, 0, 4'b0000, 2'b00, 0, 1); // 33 empty, err sticky

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #3;
            chk("rs_match", i, rs_match_o, vecs[i].ers);
            chk("rd_match", i, {2'b0, rd_match_o}, {2'b0, vecs[i].erd});
            chk("busy", i, {3'b0, busy_o}, {3'b0, vecs[i].eb});
            chk("err", i, {3'b0, err_o}, {3'b0, vecs[i].ee});
            @(posedge clk); #1;
        end

        // Asynchronous reset mid-cycle clears the sticky error at once.
        idle();
        #2 reset_n_i = 1'b0;
        #1;
        chk("async_rst_err", 100, {3'b0, err_o}, 4'b0);
        chk("async_rst_busy", 100, {3'b0, busy_o}, 4'b0);
        @(posedge clk); #1;
        reset_n_i = 1'b1;

        // Clearing x0 with nothing pending is ignored: no underflow.
        clear_v_i = 2'b11; clear_rd_i = {5'd0, 5'd0};
        score_v_i = 2'b01; score_rd_i = {5'd0, 5'd0};
        @(posedge clk); #1;
        idle();
        #3;
        chk("x0_clear_err", 101, {3'b0, err_o}, 4'b0);
        chk("x0_busy", 101, {3'b0, busy_o}, 4'b0);
        @(posedge clk); #1;

        // Underflow: clear r3 with count 0.
        clear_v_i = 2'b01; clear_rd_i = {5'd0, 5'd3};
        #3;
        chk("pre_unf_err", 102, {3'b0, err_o}, 4'b0);
        @(posedge clk); #1;
        idle();
        rs_i = {5'd0, 5'd0, 5'd0, 5'd3};
        #3;
        chk("unf_err", 103, {3'b0, err_o}, 4'b1);
        chk("unf_busy", 103, {3'b0, busy_o}, 4'b0);
        chk("unf_rs", 103, rs_match_o, 4'b0000);
        @(posedge clk); #1;

        // Flush leaves the sticky error untouched.
        idle();
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        #3;
        chk("flush_keeps_err", 104, {3'b0, err_o}, 4'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_be_scoreboard_multi.md
Name: bp_be_scoreboard_multi

Overview:
- N-issue register scoreboard for the BE checker. Generalises the dual-issue scoreboard to issue_width_p slots and clear_ports_p writeback/clear ports.
- Each architectural register gets a small pending-write counter instead of a single busy bit, so multiple outstanding writes to the same rd (WAW, e.g. long-latency FP plus a fast ALU op) are tracked correctly.
- Sits between the issue queue/dispatch and the writeback/commit paths. Produces per-slot RAW/WAW hazard flags, including intra-bundle hazards against older slots in the same bundle.

Parameters:
- issue_width_p, 2, number of instructions scored/checked per cycle (slot 0 is oldest)
- num_rs_p, 2, source operands per instruction
- clear_ports_p, 2, independent clear (writeback) ports per cycle
- reg_addr_width_p, 5, register address width; rf_els = 2**reg_addr_width_p
- cnt_width_p, 2, pending counter width per register; max outstanding = 2**cnt_width_p-1

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear of all pending counts
- score_v_i  in  issue_width_p  per-slot score request
- score_rd_i  in  issue_width_p*reg_addr_width_p  per-slot destination
- clear_v_i  in  clear_ports_p  per-port clear request
- clear_rd_i  in  clear_ports_p*reg_addr_width_p  per-port cleared register
- rs_i  in  issue_width_p*num_rs_p*reg_addr_width_p  sources per slot
- rd_i  in  issue_width_p*reg_addr_width_p  destination checked per slot
- rd_v_i  in  issue_width_p  slot carries a valid instruction (qualifies intra-bundle forwarding)
- rs_match_o  out  issue_width_p*num_rs_p  RAW hazard per source
- rd_match_o  out  issue_width_p  WAW hazard per slot
- busy_o  out  1  any counter nonzero
- err_o  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (reset_n_i low, async): all counters 0, err_o 0, busy_o 0. Hazard outputs follow combinationally from the inputs and zero state.
- Register 0 is never scored, never counted, never matched. score/clear/rs/rd of 0 has no effect and never raises a match.
- Counter update each cycle: cnt' = cnt + (#valid score ports targeting r) - (#valid clear ports targeting r). Multiple ports may target the same r in one cycle.
- Overflow: if cnt' would exceed max, the counter saturates at max and err_o sets.
- Underflow: if cnt' would be below 0, the counter floors at 0 and err_o sets.
- err_o is cleared only by reset.
- Score followed by clear is one cycle apart at minimum. A score and a clear of the same r in the same cycle net to zero change.
- flush_i takes priority over score and clear in the same cycle: all counters become 0 next cycle. err_o is unaffected.
- rs_match_o[j][k] = (rs != 0) and (cnt[rs] != 0, or any older slot m<j has rd_v_i[m] && score_v_i[m] && score_rd_i[m]==rs).
- rd_match_o[j]: same formula applied to rd_i[j].
- Hazard outputs use current registered state only. A clear arriving this cycle does not suppress a match; there is no same-cycle bypass.
- busy_o is registered-state derived: OR of all (cnt != 0). It is 0 in the cycle after a flush.
- Latency: a score in cycle t is visible in rs_match_o of later bundles from cycle t+1. It is visible to younger slots of the same bundle in cycle t.

Decomposition:
- bp_be_pkg gets:
  - scoreboard count type derived from cnt_width_p
  - localparam for rf_els
  - the flattened rs/rd array packing typedefs
- One natural sub-module, bp_be_scoreboard_counter:
  - a single register's cnt_width_p saturating up/down counter
  - takes inc count, dec count and flush
  - emits nonzero, overflow and underflow
  - instantiated rf_els-1 times (reg 0 tied off)
- Top level holds the one-hot decode/population count per register, the intra-bundle compare network, and the err_o sticky flop.

Test Plan:
- Reset/x0: deassert reset, score rd=0 on slot 0 and rs=0 on slot 1 -> no rs_match/rd_match, busy_o=0.
- Basic RAW: cycle 0 score rd=5; cycle 1 rs=5 -> rs_match=1. Cycle 1 clear 5; cycle 2 rs=5 -> rs_match=0, busy_o=0.
- WAW counting: score rd=7 in cycles 0 and 1; clear 7 in cycle 3 -> rs=7 still matches in cycle 4. Second clear in cycle 4 -> no match in cycle 5.
- Intra-bundle: slot0 score rd=9 with rd_v=1; slot1 rs=9 same cycle -> slot1 rs_match=1, slot0 rs_match for rs=9 = 0. Repeat with slot0 rd_v=0 -> slot1 no match.
- Saturation/underflow (cnt_width_p=2): score rd=3 four times -> counter holds 3 and err_o=1. Reset, then clear rd=3 with cnt=0 -> err_o=1, counter 0.
- Flush and simultaneous events: counters on 4 and 6, flush_i with score rd=4 and clear rd=6 same cycle -> next cycle all matches 0, busy_o=0. Separately, score and clear rd=8 in the same cycle with cnt=1 -> cnt stays 1.
